pll_reset_seq: RTL

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_seq_pkg.sv | 35 +++
 rtl/sync_2ff.sv | 37 +++
 rtl/pll_reset_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Shared definitions for the PLL reset sequencer: the state encoding, the
//   numeric state codes seen on the 'state' output, and small sizing helpers
//   used to dimension the sequencer's counters.
package pll_seq_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] CODE_RESET_PLL = 3'd0;
   localparam logic [STATE_W-1:0] CODE_WAIT_LOCK = 3'd1;
   localparam logic [STATE_W-1:0] CODE_STABILIZE = 3'd2;
   localparam logic [STATE_W-1:0] CODE_RUN       = 3'd3;
   localparam logic [STATE_W-1:0] CODE_FAULT     = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      ST_RESET_PLL = CODE_RESET_PLL,
      ST_WAIT_LOCK = CODE_WAIT_LOCK,
      ST_STABILIZE = CODE_STABILIZE,
      ST_RUN       = CODE_RUN,
      ST_FAULT     = CODE_FAULT
   } state_e;

   // Largest of three cycle counts; the shared counter must reach all of them.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed to hold 0..n-1 (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset, clears both stages to 0
//     d     - asynchronous input
//     q     - synchronized output (two clk edges of latency)
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next values of the two synchronizer stages.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//   Sequences PLL bring-up: pulses the PLL reset, waits for lock with a
//   timeout and bounded retries, requires a stable lock window before
//   releasing the system reset, and supervises lock while running.
//   Ports:
//     clk          - free-running reference clock (also feeds the PLL)
//     reset_n      - asynchronous active-low reset
//     pll_locked   - PLL lock flag, asynchronous to clk
//     req_reseq    - single-cycle request to re-run the bring-up sequence
//     clear_fault  - single-cycle request to leave FAULT
//     pll_rst      - active-high reset to the PLL
//     sys_reset_n  - active-low system reset, high only in RUN
//     fault        - high while in FAULT
//     state        - current state code
//     lol_count    - saturating count of loss-of-lock events seen in RUN
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic       req_reseq,
   input  logic       clear_fault,
   output logic       pll_rst,
   output logic       sys_reset_n,
   output logic       fault,
   output logic [2:0] state,
   output logic [7:0] lol_count
);

   localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
   localparam int CNT_W   = cnt_width(CNT_MAX);
   localparam int RTY_W   = cnt_width(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_LIMIT   = RTY_W'(MAX_RETRIES);

   logic             locked_s;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic [RTY_W-1:0] retry_inc;
   logic [7:0]       lol_q, lol_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_reset_n_q, sys_reset_n_d;
   logic             fault_q, fault_d;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   assign retry_inc = retry_q + RTY_W'(1);

   // Next-state, counter and registered-output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      lol_d   = lol_q;
      case (state_q)
         ST_RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (req_reseq) begin
               state_d = ST_RESET_PLL;
               cnt_d   = {CNT_W{1'b0}};
               retry_d = {RTY_W{1'b0}};
            end else if (locked_s) begin
               // The cycle that first sees lock is the first stable cycle.
               state_d = ST_STABILIZE;
               cnt_d   = CNT_W'(1);
            end else if (cnt_q == TO_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               retry_d = retry_inc;
               state_d = (retry_inc == RTY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STABILIZE: begin
            if (req_reseq) begin
               state_d = ST_RESET_PLL;
               cnt_d   = {CNT_W{1'b0}};
               retry_d = {RTY_W{1'b0}};
            end else if (!locked_s) begin
               // A glitch restarts the lock wait but is not a failed attempt.
               state_d = ST_WAIT_LOCK;
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = {CNT_W{1'b0}};
               retry_d = {RTY_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            // Loss of lock wins over a coincident re-sequence request.
            if (!locked_s) begin
               state_d = ST_RESET_PLL;
               cnt_d   = {CNT_W{1'b0}};
               lol_d   = (lol_q == 8'd255) ? lol_q : lol_q + 8'd1;
            end else if (req_reseq) begin
               state_d = ST_RESET_PLL;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FAULT: begin
            if (clear_fault) begin
               state_d = ST_RESET_PLL;
               cnt_d   = {CNT_W{1'b0}};
               retry_d = {RTY_W{1'b0}};
            end else begin
               state_d = ST_FAULT;
            end
         end
         default: begin
            state_d = ST_RESET_PLL;
            cnt_d   = {CNT_W{1'b0}};
            retry_d = {RTY_W{1'b0}};
         end
      endcase

      // Outputs are decoded from the next state so they align with state_q.
      pll_rst_d     = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
      sys_reset_n_d = (state_d == ST_RUN);
      fault_d       = (state_d == ST_FAULT);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_RESET_PLL;
         cnt_q         <= {CNT_W{1'b0}};
         retry_q       <= {RTY_W{1'b0}};
         lol_q         <= 8'd0;
         pll_rst_q     <= 1'b1;
         sys_reset_n_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_q       <= retry_d;
         lol_q         <= lol_d;
         pll_rst_q     <= pll_rst_d;
         sys_reset_n_q <= sys_reset_n_d;
         fault_q       <= fault_d;
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_reset_n = sys_reset_n_q;
   assign fault       = fault_q;
   assign state       = state_q;
   assign lol_count   = lol_q;

endmodule
